// File: rtl/key_search_pkg.sv
// rtl/key_search_pkg.sv - shared states, character constants and plaintext test for the key search
package key_search_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        WAIT,
        SCAN,
        NEXT,
        FOUND,
        FAIL
    } state_e;

    localparam logic [7:0] CHAR_SPACE = 8'd32;
    localparam logic [7:0] CHAR_A     = 8'd97;
    localparam logic [7:0] CHAR_Z     = 8'd122;

    function automatic logic is_valid_char(input logic [7:0] c);
        return (c == CHAR_SPACE) || ((c >= CHAR_A) && (c <= CHAR_Z));
    endfunction

endpackage

// File: rtl/msg_scanner.sv
// rtl/msg_scanner.sv - pipelined decrypted-message scan; early abort under KEY_SEARCH_EARLY_ABORT_EN
module msg_scanner
    import key_search_pkg::*;
#(
    parameter int MSG_LEN = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scan_start,
    input  logic       scan_abort,
    input  logic [7:0] res_q,
    output logic [7:0] res_addr,
    output logic       scan_done,
    output logic       scan_pass
);

    localparam logic [7:0] LAST_ADDR = 8'(MSG_LEN - 1);

    logic [7:0] addr_q, addr_d;
    logic       issuing_q, issuing_d;
    logic       chk_q, chk_d;
    logic       last_q, last_d;
    logic       bad_q, bad_d;
    logic       byte_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= '0;
            issuing_q <= 1'b0;
            chk_q     <= 1'b0;
            last_q    <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            issuing_q <= issuing_d;
            chk_q     <= chk_d;
            last_q    <= last_d;
            bad_q     <= bad_d;
        end
    end

    // chk_q/last_q trail the address by one cycle so they line up with res_q
    always_comb begin
        byte_ok   = is_valid_char(res_q);
        scan_pass = chk_q && !bad_q && byte_ok;
`ifdef KEY_SEARCH_EARLY_ABORT_EN
        scan_done = chk_q && (last_q || !byte_ok);
`else
        scan_done = chk_q && last_q;
`endif
    end

    always_comb begin
        addr_d    = addr_q;
        issuing_d = issuing_q;
        chk_d     = issuing_q;
        last_d    = issuing_q && (addr_q == LAST_ADDR);
        bad_d     = bad_q || (chk_q && !byte_ok);
        if (issuing_q) begin
            if (addr_q == LAST_ADDR) issuing_d = 1'b0;
            else                     addr_d    = addr_q + 8'd1;
        end
`ifdef KEY_SEARCH_EARLY_ABORT_EN
        if (scan_done) begin
            issuing_d = 1'b0;
            chk_d     = 1'b0;
            last_d    = 1'b0;
        end
`endif
        if (scan_abort) begin
            issuing_d = 1'b0;
            chk_d     = 1'b0;
            last_d    = 1'b0;
        end else if (scan_start) begin
            addr_d    = '0;
            issuing_d = 1'b1;
            chk_d     = 1'b0;
            last_d    = 1'b0;
            bad_d     = 1'b0;
        end
    end

    assign res_addr = addr_q;

endmodule

// File: rtl/key_search_ctrl.sv
// rtl/key_search_ctrl.sv - brute-force RC4 key scheduler; KEY_SEARCH_EARLY_ABORT_EN selects early scan abort
module key_search_ctrl
    import key_search_pkg::*;
#(
    parameter int               KEY_W     = 24,
    parameter logic [KEY_W-1:0] KEY_START = 24'h000000,
    parameter logic [KEY_W-1:0] KEY_END   = 24'h3FFFFF,
    parameter int               MSG_LEN   = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    output logic [KEY_W-1:0] key,
    output logic             core_clear,
    output logic             decrypt_start,
    input  logic             decrypt_complete,
    output logic [7:0]       res_addr,
    input  logic [7:0]       res_q,
    output logic             busy,
    output logic             found,
    output logic             exhausted
);

    state_e           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             found_q, found_d;
    logic             exh_q, exh_d;
    logic             scan_start, scan_done, scan_pass;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start)            state_d = CLEAR;
            CLEAR:                       state_d = RUN;
            RUN:                         state_d = WAIT;
            WAIT:  if (decrypt_complete) state_d = SCAN;
            SCAN:  if (scan_done)        state_d = scan_pass ? FOUND : NEXT;
            NEXT:                        state_d = (key_q == KEY_END) ? FAIL : CLEAR;
            FOUND: if (start)            state_d = IDLE;
            FAIL:  if (start)            state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
        if (stop) state_d = IDLE;
    end

    // Abort leaves through a core_clear so the core is idle when the next search begins
    always_comb begin
        busy          = !(state_q inside {IDLE, FOUND, FAIL});
        core_clear    = (state_q == CLEAR) || (stop && (state_q != IDLE));
        decrypt_start = ((state_q == RUN) || (state_q == WAIT)) && !stop;
        scan_start    = (state_q == WAIT) && decrypt_complete && !stop;
        key           = key_q;
        found         = found_q;
        exhausted     = exh_q;
    end

    always_comb begin
        key_d   = key_q;
        found_d = found_q;
        exh_d   = exh_q;
        if (stop) begin
            found_d = 1'b0;
            exh_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    key_d   = KEY_START;
                    found_d = 1'b0;
                    exh_d   = 1'b0;
                end
                SCAN: if (scan_done && scan_pass) found_d = 1'b1;
                NEXT: begin
                    if (key_q == KEY_END) exh_d = 1'b1;
                    else                  key_d = key_q + KEY_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q   <= '0;
            found_q <= 1'b0;
            exh_q   <= 1'b0;
        end else begin
            key_q   <= key_d;
            found_q <= found_d;
            exh_q   <= exh_d;
        end
    end

    msg_scanner #(
        .MSG_LEN(MSG_LEN)
    ) u_scanner (
        .clk       (clk),
        .reset_n   (reset_n),
        .scan_start(scan_start),
        .scan_abort(stop),
        .res_q     (res_q),
        .res_addr  (res_addr),
        .scan_done (scan_done),
        .scan_pass (scan_pass)
    );

endmodule

// File: tb/tb_key_search_ctrl.sv
// tb/tb_key_search_ctrl.sv - self-checking bench for key_search_ctrl with core and RAM models
module tb_key_search_ctrl;

    localparam int KW = 24;
    localparam int ML = 4;
    localparam int NK = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [KW-1:0] key;
    logic          core_clear;
    logic          decrypt_start;
    logic          decrypt_complete;
    logic [7:0]    res_addr;
    logic [7:0]    res_q;
    logic          busy;
    logic          found;
    logic          exhausted;

    always #5 clk = ~clk;

    key_search_ctrl #(
        .KEY_W    (KW),
        .KEY_START(24'h000000),
        .KEY_END  (24'h000007),
        .MSG_LEN  (ML)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .stop            (stop),
        .key             (key),
        .core_clear      (core_clear),
        .decrypt_start   (decrypt_start),
        .decrypt_complete(decrypt_complete),
        .res_addr        (res_addr),
        .res_q           (res_q),
        .busy            (busy),
        .found           (found),
        .exhausted       (exhausted)
    );

    logic [7:0] msgs [0:NK-1][0:ML-1];

    // Decrypt core completes after 10 cycles of decrypt_start
    int core_cnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_cnt         <= 0;
            decrypt_complete <= 1'b0;
        end else if (core_clear) begin
            core_cnt         <= 0;
            decrypt_complete <= 1'b0;
        end else if (decrypt_start && !decrypt_complete) begin
            core_cnt <= core_cnt + 1;
            if (core_cnt == 9) decrypt_complete <= 1'b1;
        end
    end

    always @(posedge clk)
        res_q <= (res_addr < ML) ? msgs[key[2:0]][res_addr[1:0]] : 8'h00;

    int   cc_rises = 0;
    int   ds_rises = 0;
    logic cc_p = 1'b0;
    logic ds_p = 1'b0;
    bit   in_post = 1'b0;
    int   qlen = 0;
    int   ql [$];

    // Length of the quiet busy stretch after each decrypt_start fall (scan plus any NEXT cycle)
    always @(negedge clk) begin
        if (core_clear && !cc_p) cc_rises <= cc_rises + 1;
        if (decrypt_start && !ds_p) ds_rises <= ds_rises + 1;
        if (in_post) begin
            if (busy && !decrypt_start && !core_clear) qlen <= qlen + 1;
            else begin
                ql.push_back(qlen);
                in_post <= 1'b0;
            end
        end else if (ds_p && !decrypt_start && busy && !core_clear) begin
            in_post <= 1'b1;
            qlen    <= 1;
        end
        cc_p <= core_clear;
        ds_p <= decrypt_start;
    end

    int n_cmp = 0;
    int n_fail = 0;
    int base_cc, base_ds, base_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit char_ok(input logic [7:0] c);
        return (c == 8'd32) || (c >= 8'd97 && c <= 8'd122);
    endfunction

    function automatic logic [7:0] rand_valid();
        int r;
        r = $urandom_range(0, 26);
        return (r == 26) ? 8'd32 : 8'(97 + r);
    endfunction

    task automatic fill_bad();
        for (int k = 0; k < NK; k++) begin
            for (int i = 0; i < ML - 1; i++) msgs[k][i] = rand_valid();
            msgs[k][ML-1] = 8'(123 + $urandom_range(0, 132));
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < NK; k++)
            for (int i = 0; i < ML; i++)
                msgs[k][i] = ($urandom_range(0, 3) == 0) ? rand_valid() : 8'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) begin
            int g;
            g = $urandom_range(0, NK - 1);
            for (int i = 0; i < ML; i++) msgs[g][i] = rand_valid();
        end
    endtask

    task automatic set_msg(input int k, input logic [31:0] bytes);
        for (int i = 0; i < ML; i++) msgs[k][i] = bytes[31-8*i -: 8];
    endtask

    // Reference: the first key whose whole message is plaintext wins, otherwise all keys are tried
    task automatic model(output bit f, output int k, output int tried);
        bit ok;
        f = 1'b0;
        k = NK - 1;
        tried = NK;
        for (int kk = 0; kk < NK; kk++) begin
            ok = 1'b1;
            for (int i = 0; i < ML; i++) if (!char_ok(msgs[kk][i])) ok = 1'b0;
            if (ok && !f) begin
                f = 1'b1;
                k = kk;
                tried = kk + 1;
            end
        end
    endtask

    task automatic begin_search();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        base_cc = cc_rises;
        base_ds = ds_rises;
        base_q  = ql.size();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            tick();
            if (found || exhausted) seen = 1'b1;
        end
        tick();
        n_cmp++;
        assert (seen)
        else begin
            n_fail++;
            $error("FAIL wait_done: observed %0b expected 1", seen);
        end
    endtask

    task automatic wait_key(input int k, input bit on_addr, input int a);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            tick();
            if (key == k && (on_addr ? (res_addr == a && busy && !decrypt_start) : decrypt_start))
                seen = 1'b1;
        end
        n_cmp++;
        assert (seen)
        else begin
            n_fail++;
            $error("FAIL wait_key: observed %0b expected 1", seen);
        end
    endtask

    task automatic check_result(input string tag);
        bit f;
        int k, tried;
        model(f, k, tried);
        chk({tag, ".found"}, 32'(found), 32'(f));
        chk({tag, ".exhausted"}, 32'(exhausted), 32'(!f));
        chk({tag, ".key"}, 32'(key), 32'(k));
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".clears"}, 32'(cc_rises - base_cc), 32'(tried));
        chk({tag, ".starts"}, 32'(ds_rises - base_ds), 32'(tried));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".key"}, 32'(key), 32'd0);
        chk({tag, ".res_addr"}, 32'(res_addr), 32'd0);
        chk({tag, ".core_clear"}, 32'(core_clear), 32'd0);
        chk({tag, ".decrypt_start"}, 32'(decrypt_start), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".found"}, 32'(found), 32'd0);
        chk({tag, ".exhausted"}, 32'(exhausted), 32'd0);
    endtask

    initial begin
        int exp_issued;
        int l0, l1;
        fill_bad();
        #12;
        check_zero("reset");
        tick();
        reset_n = 1'b1;
        tick();

        fill_bad();
        set_msg(5, {8'd97, 8'd98, 8'd99, 8'd100});
        begin_search();
        wait_done();
        check_result("valid_at_5");

        fill_bad();
        begin_search();
        wait_done();
        check_result("exhaust");

        fill_bad();
        set_msg(0, {8'd96, 8'd97, 8'd122, 8'd32});
        set_msg(1, {8'd32, 8'd97, 8'd122, 8'd123});
        set_msg(2, {8'd32, 8'd97, 8'd122, 8'd32});
        begin_search();
        wait_done();
        check_result("boundary");

`ifdef KEY_SEARCH_EARLY_ABORT_EN
        exp_issued = 1;
`else
        exp_issued = ML;
`endif
        fill_bad();
        set_msg(0, {8'd96, 8'd97, 8'd97, 8'd97});
        set_msg(1, {8'd97, 8'd98, 8'd99, 8'd100});
        begin_search();
        wait_done();
        check_result("early_abort");
        l0 = (ql.size() > base_q) ? ql[base_q] : -99;
        l1 = (ql.size() > base_q + 1) ? ql[base_q+1] : -99;
        chk("early_abort.issued", 32'(l0 - 2), 32'(exp_issued));
        chk("early_abort.full_scan", 32'(l1), 32'(ML + 1));

        fill_bad();
        begin_search();
        wait_key(3, 1'b0, 0);
        tick();
        tick();
        base_cc = cc_rises;
        stop = 1'b1;
        tick();
        chk("stop.busy", 32'(busy), 32'd0);
        chk("stop.decrypt_start", 32'(decrypt_start), 32'd0);
        chk("stop.found", 32'(found), 32'd0);
        chk("stop.exhausted", 32'(exhausted), 32'd0);
        chk("stop.key", 32'(key), 32'd3);
        stop = 1'b0;
        tick();
        tick();
        chk("stop.clear_pulses", 32'(cc_rises - base_cc), 32'd1);
        chk("stop.idle_hold", 32'(busy), 32'd0);

        fill_bad();
        begin_search();
        wait_key(2, 1'b1, 2);
        reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        tick();
        reset_n = 1'b1;
        tick();
        begin_search();
        chk("restart.key", 32'(key), 32'd0);
        chk("restart.core_clear", 32'(core_clear), 32'd1);
        wait_done();
        check_result("restart");

        for (int r = 0; r < 12; r++) begin
            fill_random();
            begin_search();
            wait_done();
            check_result($sformatf("random%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
